// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle fetch/decode/execute/memory/writeback phase sequencer with trap entry.
// Latency: one state per clock; phase strobes are combinational from state; trap_cause is registered.
// Stalls on mem_busy/reg_busy handshakes; optional memory-wait watchdog via `define MC_SEQ_WATCHDOG_EN.

module mc_sequencer #(
  parameter int NUM_EXC     = 3,
  parameter int TIMEOUT_CYC = 255,
  localparam int CAUSE_W    = $clog2(NUM_EXC + 3)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_busy,
  input  logic               mem_valid,
  input  logic               reg_busy,
  input  logic               irq_pending,
  input  logic [NUM_EXC-1:0] exc,
  input  logic               dec_mem,
  input  logic               dec_store,
  input  logic               dec_rd_we,
  input  logic               dec_mret,
  input  logic               dec_csrw,
  input  logic               dec_illegal,
  output logic               mem_ce,
  output logic               mem_we,
  output logic               fetchflag,
  output logic               memflag,
  output logic               reg_enable,
  output logic               wbflag,
  output logic               pcflag,
  output logic               jump_to_isr,
  output logic               mret,
  output logic               csr_write,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic               timeout_err,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    S_RST          = 4'd0,
    S_FETCH_AWAIT  = 4'd1,
    S_FETCH        = 4'd2,
    S_DECODE_AWAIT = 4'd3,
    S_DECODE       = 4'd4,
    S_EXECUTE      = 4'd5,
    S_MEM_AWAIT    = 4'd6,
    S_MEM          = 4'd7,
    S_WRD_AWAIT    = 4'd8,
    S_WRD          = 4'd9,
    S_WRITEBACK    = 4'd10,
    S_TRAP         = 4'd11
  } state_t;

  localparam logic [CAUSE_W-1:0] CAUSE_ILL = CAUSE_W'(NUM_EXC);
  localparam logic [CAUSE_W-1:0] CAUSE_WD  = CAUSE_W'(NUM_EXC + 1);
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ = CAUSE_W'(NUM_EXC + 2);
  localparam logic [15:0]        WD_LIMIT  = 16'(TIMEOUT_CYC - 1);

  state_t               state;
  state_t               state_next;
  logic [CAUSE_W-1:0]   cause_next;
  logic [CAUSE_W-1:0]   exc_idx;
  logic                 exc_any;
  logic                 wd_expired;
  logic                 wr_rd;

  assign exc_any = |exc;
  // mret and csr writes never have a register write-back phase.
  assign wr_rd   = dec_rd_we & ~dec_mret & ~dec_csrw;

  // Priority encode the exception sources: lowest set index wins.
  always_comb begin
    exc_idx = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc[i]) exc_idx = CAUSE_W'(i);
    end
  end

  // State register; reset forces RST asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_next;
  end

  // Next-state and trap cause selection. Exit conditions are tested before the watchdog.
  always_comb begin
    state_next = state;
    cause_next = '0;
    case (state)
      S_RST:          state_next = S_FETCH_AWAIT;
      S_FETCH_AWAIT: begin
        if (exc_any) begin
          state_next = S_TRAP;
          cause_next = exc_idx;
        end else if (mem_busy) begin
          state_next = S_FETCH;
        end else if (wd_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_WD;
        end
      end
      S_FETCH: begin
        if (!mem_busy) begin
          state_next = S_DECODE_AWAIT;
        end else if (wd_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_WD;
        end
      end
      S_DECODE_AWAIT: if (reg_busy)  state_next = S_DECODE;
      S_DECODE:       if (!reg_busy) state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (dec_illegal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILL;
        end else if (dec_mem) begin
          state_next = S_MEM_AWAIT;
        end else if (wr_rd) begin
          state_next = S_WRD_AWAIT;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_MEM_AWAIT: begin
        if (exc_any) begin
          state_next = S_TRAP;
          cause_next = exc_idx;
        end else if (mem_busy) begin
          state_next = S_MEM;
        end else if (wd_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_WD;
        end
      end
      S_MEM: begin
        if (!mem_busy) begin
          state_next = wr_rd ? S_WRD_AWAIT : S_WRITEBACK;
        end else if (wd_expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_WD;
        end
      end
      S_WRD_AWAIT:    if (reg_busy)  state_next = S_WRD;
      S_WRD:          if (!reg_busy) state_next = S_WRITEBACK;
      S_WRITEBACK: begin
        if (irq_pending) begin
          state_next = S_TRAP;
          cause_next = CAUSE_IRQ;
        end else begin
          state_next = S_FETCH_AWAIT;
        end
      end
      S_TRAP:         state_next = S_FETCH_AWAIT;
      default:        state_next = S_RST;
    endcase
  end

  // Capture the cause on the edge that enters TRAP; hold it otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     trap_cause <= '0;
    else if (state_next == S_TRAP) trap_cause <= cause_next;
  end

`ifdef MC_SEQ_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        timeout_q;
  logic        in_mem_wait;
  logic        enter_wait;

  assign in_mem_wait = (state == S_FETCH_AWAIT) || (state == S_FETCH) ||
                       (state == S_MEM_AWAIT)   || (state == S_MEM);
  assign enter_wait  = ((state_next == S_FETCH_AWAIT) && (state != S_FETCH_AWAIT)) ||
                       ((state_next == S_MEM_AWAIT)   && (state != S_MEM_AWAIT));
  assign wd_expired  = (wd_cnt == WD_LIMIT);
  assign timeout_err = timeout_q;

  // Wait-cycle counter: restarts on entering a memory wait, saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          wd_cnt <= '0;
    else if (enter_wait)                wd_cnt <= '0;
    else if (in_mem_wait && ~&wd_cnt)   wd_cnt <= wd_cnt + 16'd1;
  end

  // Sticky flag: set whenever a watchdog trap is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                               timeout_q <= 1'b0;
    else if (state_next == S_TRAP && cause_next == CAUSE_WD) timeout_q <= 1'b1;
  end
`else
  // Memory waits are unbounded; the limit has no consumer in this build.
  logic unused_cfg;
  assign unused_cfg  = ^WD_LIMIT;
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Phase strobes decoded from the current state.
  always_comb begin
    mem_ce      = 1'b1;
    memflag     = 1'b0;
    fetchflag   = 1'b0;
    reg_enable  = 1'b0;
    wbflag      = 1'b0;
    pcflag      = 1'b0;
    jump_to_isr = 1'b0;
    case (state)
      S_FETCH_AWAIT:  mem_ce = 1'b0;
      S_FETCH: begin
        mem_ce    = 1'b0;
        fetchflag = mem_valid;
      end
      S_MEM_AWAIT, S_MEM: begin
        mem_ce  = 1'b0;
        memflag = 1'b1;
      end
      S_DECODE_AWAIT: reg_enable = 1'b1;
      S_WRD_AWAIT: begin
        reg_enable = 1'b1;
        wbflag     = 1'b1;
      end
      S_WRD:          wbflag = 1'b1;
      S_WRITEBACK:    pcflag = 1'b1;
      S_TRAP:         jump_to_isr = 1'b1;
      default: ;
    endcase
  end

  assign mem_we    = memflag & dec_store;
  assign mret      = pcflag & dec_mret;
  assign csr_write = pcflag & dec_csrw;
  assign state_o   = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: directed and randomized instruction plans for mc_sequencer.
// Each instruction is described by its phase lengths; expected state per cycle follows from the plan.
// Outputs are sampled 1 time unit after the falling edge, inputs are driven on the falling edge.

module tb_mc_sequencer;

  localparam int NUM_EXC = 3;
  localparam int TO      = 8;
`ifdef MC_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int RS = 0, FA = 1, FE = 2, DA = 3, DE = 4, EX = 5;
  localparam int MA = 6, ME = 7, WA = 8, WR = 9, WB = 10, TR = 11;

  typedef struct {
    int         fa, f, fk;
    logic [2:0] fe;
    int         da, d;
    int         ma, m, mk;
    logic [2:0] me;
    int         wa, w;
    bit         irq;
    bit         mem, store, rdwe, mret, csrw, ill;
  } plan_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_busy, mem_valid, reg_busy, irq_pending;
  logic [2:0] exc;
  logic       dec_mem, dec_store, dec_rd_we, dec_mret, dec_csrw, dec_illegal;
  logic       mem_ce, mem_we, fetchflag, memflag, reg_enable, wbflag, pcflag;
  logic       jump_to_isr, mret, csr_write, timeout_err;
  logic [2:0] trap_cause;
  logic [3:0] state_o;

  int         compared   = 0;
  int         mismatched = 0;
  logic [2:0] exp_cause;
  logic       exp_to;

  mc_sequencer #(.NUM_EXC(NUM_EXC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_busy(mem_busy), .mem_valid(mem_valid), .reg_busy(reg_busy),
    .irq_pending(irq_pending), .exc(exc),
    .dec_mem(dec_mem), .dec_store(dec_store), .dec_rd_we(dec_rd_we),
    .dec_mret(dec_mret), .dec_csrw(dec_csrw), .dec_illegal(dec_illegal),
    .mem_ce(mem_ce), .mem_we(mem_we), .fetchflag(fetchflag), .memflag(memflag),
    .reg_enable(reg_enable), .wbflag(wbflag), .pcflag(pcflag),
    .jump_to_isr(jump_to_isr), .mret(mret), .csr_write(csr_write),
    .trap_cause(trap_cause), .timeout_err(timeout_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [2:0] lowest_set(input logic [2:0] v);
    logic [2:0] r = 3'd0;
    for (int i = 2; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Output table: what each phase must show.
  task automatic check_outputs(input int st);
    bit in_mem = (st == FA) || (st == FE) || (st == MA) || (st == ME);
    bit mf     = (st == MA) || (st == ME);
    chk("state_o",     16'(state_o),     16'(st));
    chk("mem_ce",      16'(mem_ce),      16'(!in_mem));
    chk("memflag",     16'(memflag),     16'(mf));
    chk("mem_we",      16'(mem_we),      16'(mf && dec_store));
    chk("fetchflag",   16'(fetchflag),   16'(st == FE && mem_valid));
    chk("reg_enable",  16'(reg_enable),  16'(st == DA || st == WA));
    chk("wbflag",      16'(wbflag),      16'(st == WA || st == WR));
    chk("pcflag",      16'(pcflag),      16'(st == WB));
    chk("mret",        16'(mret),        16'(st == WB && dec_mret));
    chk("csr_write",   16'(csr_write),   16'(st == WB && dec_csrw));
    chk("jump_to_isr", 16'(jump_to_isr), 16'(st == TR));
    chk("trap_cause",  16'(trap_cause),  16'(exp_cause));
    chk("timeout_err", 16'(timeout_err), 16'(exp_to));
  endtask

  task automatic cyc(input int st, input logic mb, input logic rb, input logic irq,
                     input logic [2:0] ex);
    @(negedge clk);
    mem_busy    = mb;
    reg_busy    = rb;
    irq_pending = irq;
    exc         = ex;
    mem_valid   = rbit();
    #1;
    check_outputs(st);
  endtask

  task automatic trap_cycle();
    cyc(TR, rbit(), rbit(), rbit(), 3'($urandom));
  endtask

  // Await state for n_aw cycles then busy state for n_b cycles, timed from wait entry.
  task automatic mem_phase(input int aw, input int n_aw, input int n_b, input int exc_k,
                           input logic [2:0] exv, output bit trapped);
    int total = n_aw + n_b;
    trapped = 1'b0;
    for (int t = 0; t < total; t++) begin
      bit in_aw = (t < n_aw);
      bit ext   = in_aw ? (t == n_aw - 1) : (t == total - 1);
      if (in_aw && t == exc_k) begin
        cyc(aw, rbit(), rbit(), rbit(), exv);
        exp_cause = lowest_set(exv);
        trapped   = 1'b1;
        return;
      end
      cyc(in_aw ? aw : aw + 1, in_aw ? ext : !ext, rbit(), rbit(),
          in_aw ? 3'd0 : 3'($urandom));
      if (WD_EN && t == TO - 1 && !ext) begin
        exp_cause = 3'(NUM_EXC + 1);
        exp_to    = 1'b1;
        trapped   = 1'b1;
        return;
      end
    end
  endtask

  task automatic reg_phase(input int aw, input int n_aw, input int n_b);
    int total = n_aw + n_b;
    for (int t = 0; t < total; t++) begin
      bit in_aw = (t < n_aw);
      bit ext   = in_aw ? (t == n_aw - 1) : (t == total - 1);
      cyc(in_aw ? aw : aw + 1, rbit(), in_aw ? ext : !ext, rbit(), 3'($urandom));
    end
  endtask

  task automatic do_instr(input plan_t p);
    bit tr;
    dec_mem = p.mem; dec_store = p.store; dec_rd_we = p.rdwe;
    dec_mret = p.mret; dec_csrw = p.csrw; dec_illegal = p.ill;
    mem_phase(FA, p.fa, p.f, p.fk, p.fe, tr);
    if (tr) begin trap_cycle(); return; end
    reg_phase(DA, p.da, p.d);
    cyc(EX, rbit(), rbit(), rbit(), 3'($urandom));
    if (p.ill) begin
      exp_cause = 3'(NUM_EXC);
      trap_cycle();
      return;
    end
    if (p.mem) begin
      mem_phase(MA, p.ma, p.m, p.mk, p.me, tr);
      if (tr) begin trap_cycle(); return; end
    end
    if (p.rdwe && !p.mret && !p.csrw) reg_phase(WA, p.wa, p.w);
    cyc(WB, rbit(), rbit(), p.irq, 3'($urandom));
    if (p.irq) begin
      exp_cause = 3'(NUM_EXC + 2);
      trap_cycle();
    end
  endtask

  function automatic plan_t base_plan();
    plan_t p;
    p.fa = 1; p.f = 2; p.fk = 99; p.fe = 3'd0;
    p.da = 1; p.d = 1;
    p.ma = 1; p.m = 2; p.mk = 99; p.me = 3'd0;
    p.wa = 1; p.w = 1; p.irq = 1'b0;
    p.mem = 1'b0; p.store = 1'b0; p.rdwe = 1'b0;
    p.mret = 1'b0; p.csrw = 1'b0; p.ill = 1'b0;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.fa    = $urandom_range(1, 3);
    p.f     = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(1, 4);
    p.fk    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, p.fa - 1) : 99;
    p.fe    = 3'($urandom_range(1, 7));
    p.da    = $urandom_range(1, 3);
    p.d     = $urandom_range(1, 3);
    p.ma    = $urandom_range(1, 3);
    p.m     = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(1, 4);
    p.mk    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, p.ma - 1) : 99;
    p.me    = 3'($urandom_range(1, 7));
    p.wa    = $urandom_range(1, 3);
    p.w     = $urandom_range(1, 3);
    p.irq   = ($urandom_range(0, 3) == 0);
    p.mem   = rbit();
    p.store = p.mem && rbit();
    p.rdwe  = rbit();
    p.mret  = ($urandom_range(0, 5) == 0);
    p.csrw  = ($urandom_range(0, 5) == 0);
    p.ill   = ($urandom_range(0, 9) == 0);
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    plan_t p;
    bit    tr;
    reset = 1'b1;
    mem_busy = 1'b0; mem_valid = 1'b0; reg_busy = 1'b0; irq_pending = 1'b0; exc = 3'd0;
    dec_mem = 1'b0; dec_store = 1'b0; dec_rd_we = 1'b0;
    dec_mret = 1'b0; dec_csrw = 1'b0; dec_illegal = 1'b0;
    exp_cause = 3'd0;
    exp_to    = 1'b0;

    // Reset held across edges: RST, mem_ce high, strobes low.
    #2;
    check_outputs(RS);
    repeat (2) @(negedge clk);
    mem_valid = 1'b1;
    #1;
    check_outputs(RS);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs(RS);

    // ALU op with register write-back.
    p = base_plan(); p.rdwe = 1'b1;
    do_instr(p);
    // Store: memory phases with mem_we, no WRD phases.
    p = base_plan(); p.mem = 1'b1; p.store = 1'b1; p.m = 3;
    do_instr(p);
    // Exceptions 3'b110 in MEM_AWAIT: cause 1.
    p = base_plan(); p.mem = 1'b1; p.rdwe = 1'b1; p.mk = 0; p.me = 3'b110;
    do_instr(p);
    // Illegal instruction: cause NUM_EXC.
    p = base_plan(); p.ill = 1'b1; p.mem = 1'b1;
    do_instr(p);
    // Exception during fetch wait.
    p = base_plan(); p.fa = 2; p.fk = 1; p.fe = 3'b100;
    do_instr(p);
    // mret with rd write requested, interrupt taken at WRITEBACK: cause NUM_EXC+2.
    p = base_plan(); p.mem = 1'b1; p.rdwe = 1'b1; p.mret = 1'b1; p.irq = 1'b1; p.m = 4;
    do_instr(p);
    // csr write also suppresses WRD.
    p = base_plan(); p.rdwe = 1'b1; p.csrw = 1'b1;
    do_instr(p);
    // Memory stuck busy in FETCH: timeout exactly TO cycles after wait entry (if enabled).
    p = base_plan(); p.f = 20; p.rdwe = 1'b1;
    do_instr(p);
    // Busy drops on the last allowed cycle: no timeout.
    p = base_plan(); p.f = TO - 1;
    do_instr(p);
    // Same boundary in the data memory phase.
    p = base_plan(); p.mem = 1'b1; p.ma = 2; p.m = TO - 2;
    do_instr(p);
    p = base_plan(); p.mem = 1'b1; p.ma = 2; p.m = 15;
    do_instr(p);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      do_instr(rand_plan());
    end

    // Asynchronous reset in the middle of MEM.
    p = base_plan(); p.mem = 1'b1; p.rdwe = 1'b1;
    dec_mem = 1'b1; dec_store = 1'b0; dec_rd_we = 1'b1;
    dec_mret = 1'b0; dec_csrw = 1'b0; dec_illegal = 1'b0;
    mem_phase(FA, 1, 1, 99, 3'd0, tr);
    reg_phase(DA, 1, 1);
    cyc(EX, 1'b0, 1'b0, 1'b0, 3'd0);
    cyc(MA, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(ME, 1'b1, 1'b0, 1'b1, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    exp_cause = 3'd0;
    exp_to    = 1'b0;
    check_outputs(RS);
    @(negedge clk);
    #1;
    check_outputs(RS);
    reset = 1'b0;
    #1;
    check_outputs(RS);
    do_instr(p);
    for (int n = 0; n < 20; n++) begin
      do_instr(rand_plan());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
